// File: rtl/cmac_pkg.sv
// Shared types and arithmetic helpers for the sparse complex MAC-accumulate engine.
// Define CMAC_SAT_EN to saturate narrowing and accumulation instead of wrapping.
package cmac_pkg;

   localparam int unsigned CMAC_DATALEN = 16;
   localparam int unsigned MAC_LAT      = 3;

   typedef struct packed {
      logic [CMAC_DATALEN-1:0] im;
      logic [CMAC_DATALEN-1:0] re;
   } cmplx_t;

   typedef enum logic [1:0] {StIdle, StAccum, StDrain, StDone} state_e;

   // Narrow a wide signed value to w bits; the caller keeps the low w bits of the result.
   function automatic logic signed [63:0] narrow(input logic signed [63:0] x,
                                                 input int unsigned      w);
`ifdef CMAC_SAT_EN
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
`else
      return (x <<< (64 - w)) >>> (64 - w);
`endif
   endfunction

endpackage

// File: rtl/cmplx_mul_pipe.sv
// Single-lane registered complex multiplier: p = (a * b) >>> FRACLEN, narrowed to DATALEN.
// Narrowing saturates when CMAC_SAT_EN is defined (handled in cmac_pkg::narrow).
module cmplx_mul_pipe
   import cmac_pkg::*;
#(
   parameter int unsigned DATALEN = 16,
   parameter int unsigned FRACLEN = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [2*DATALEN-1:0] a,
   input  logic [2*DATALEN-1:0] b,
   output logic [2*DATALEN-1:0] p
);

   logic signed [DATALEN-1:0]   ar, ai, br, bi;
   logic signed [63:0]          re_full, im_full;
   logic        [2*DATALEN-1:0] p_d, p_q;

   assign ar = a[DATALEN-1:0];
   assign ai = a[2*DATALEN-1:DATALEN];
   assign br = b[DATALEN-1:0];
   assign bi = b[2*DATALEN-1:DATALEN];

   always_comb begin
      re_full = (64'(ar) * 64'(br) - 64'(ai) * 64'(bi)) >>> FRACLEN;
      im_full = (64'(ar) * 64'(bi) + 64'(ai) * 64'(br)) >>> FRACLEN;
      p_d     = {DATALEN'(narrow(im_full, DATALEN)), DATALEN'(narrow(re_full, DATALEN))};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q <= '0;
      end else if (en) begin
         p_q <= p_d;
      end
   end

   assign p = p_q;

endmodule

// File: rtl/sparse_cmac_accum.sv
// Sparse complex MAC-accumulate engine: multiply, psum read with forwarding, masked write-back.
// Define CMAC_SAT_EN for saturating arithmetic; otherwise adds and narrowing wrap.
module sparse_cmac_accum
   import cmac_pkg::*;
#(
   parameter int unsigned DATALEN = 16,
   parameter int unsigned FRACLEN = 14,
   parameter int unsigned PARAKRN = 8,
   parameter int unsigned INDXLEN = 6
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           cfg_first,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic                           s_last,
   input  logic [INDXLEN-1:0]             s_indx,
   input  logic [2*DATALEN-1:0]           s_act,
   input  logic [PARAKRN*2*DATALEN-1:0]   s_krn,
   input  logic [PARAKRN-1:0]             s_kmask,
   input  logic                           rd_en,
   input  logic [INDXLEN-1:0]             rd_addr,
   output logic [PARAKRN*2*DATALEN-1:0]   rd_data,
   output logic                           busy,
   output logic                           done
);

   localparam int unsigned DEPTH = 2 ** INDXLEN;
   localparam int unsigned CW    = 2 * DATALEN;

   state_e                   state_q, state_d;
   logic                     first_q;
   logic [DEPTH-1:0]         touched_q;
   logic                     s1_v_q, s2_v_q;
   logic [INDXLEN-1:0]       s1_idx_q, s2_idx_q;
   logic [PARAKRN-1:0]       s1_mask_q, s2_mask_q;
   logic [PARAKRN*CW-1:0]    s1_prod, s2_prod_q, s2_old_q, s2_old_d, wr_val, rd_word;
   logic                     accept, pass_start, overwrite, s2_hit;

   assign s_ready    = (state_q == StAccum);
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign accept     = s_valid && s_ready;
   assign pass_start = start && (state_q == StIdle);
   assign overwrite  = first_q && !touched_q[s2_idx_q];
   // Beat entering S2 targets the entry S3 is writing this cycle.
   assign s2_hit     = s2_v_q && (s1_idx_q == s2_idx_q);

   for (genvar k = 0; k < PARAKRN; k++) begin : g_lane
      logic [CW-1:0]      mem [DEPTH];
      logic [CW-1:0]      old, prod, wr;
      logic [DATALEN-1:0] sum_re, sum_im;

      cmplx_mul_pipe #(
         .DATALEN(DATALEN),
         .FRACLEN(FRACLEN)
      ) u_mul (
         .clk(clk),
         .rst(rst),
         .en (accept),
         .a  (s_act),
         .b  (s_krn[k*CW +: CW]),
         .p  (s1_prod[k*CW +: CW])
      );

      assign old    = s2_old_q[k*CW +: CW];
      assign prod   = s2_prod_q[k*CW +: CW];
      assign sum_re = DATALEN'(narrow(64'(signed'(old[DATALEN-1:0]))
                                      + 64'(signed'(prod[DATALEN-1:0])), DATALEN));
      assign sum_im = DATALEN'(narrow(64'(signed'(old[CW-1:DATALEN]))
                                      + 64'(signed'(prod[CW-1:DATALEN])), DATALEN));
      assign wr     = overwrite ? prod : {sum_im, sum_re};

      assign wr_val[k*CW +: CW]   = wr;
      assign s2_old_d[k*CW +: CW] = (s2_hit && s2_mask_q[k]) ? wr : mem[s1_idx_q];
      assign rd_word[k*CW +: CW]  = mem[rd_addr];

      always_ff @(posedge clk) begin
         if (s2_v_q && s2_mask_q[k]) begin
            mem[s2_idx_q] <= wr;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StAccum;
         StAccum: if (accept && s_last) state_d = StDrain;
         StDrain: if (!s1_v_q && !s2_v_q) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         first_q   <= 1'b0;
         touched_q <= '0;
         s1_v_q    <= 1'b0;
         s2_v_q    <= 1'b0;
         s1_idx_q  <= '0;
         s2_idx_q  <= '0;
         s1_mask_q <= '0;
         s2_mask_q <= '0;
         s2_prod_q <= '0;
         s2_old_q  <= '0;
         rd_data   <= '0;
      end else begin
         state_q <= state_d;
         s1_v_q  <= accept;
         s2_v_q  <= s1_v_q;
         if (accept) begin
            s1_idx_q  <= s_indx;
            s1_mask_q <= s_kmask;
         end
         if (s1_v_q) begin
            s2_idx_q  <= s1_idx_q;
            s2_mask_q <= s1_mask_q;
            s2_prod_q <= s1_prod;
            s2_old_q  <= s2_old_d;
         end
         if (pass_start) begin
            first_q   <= cfg_first;
            touched_q <= '0;
         end else if (s2_v_q) begin
            touched_q[s2_idx_q] <= 1'b1;
         end
         if (rd_en && (state_q == StIdle)) begin
            rd_data <= rd_word;
         end
      end
   end

endmodule

// File: doc/sparse_cmac_accum.md
Name: sparse_cmac_accum

Overview:
- Parametrised spectral-domain sparse complex MAC-accumulate engine for one input tile.
- Consumes a stream of (spectral index, input coefficient, per-lane kernel coefficient + sparsity mask) and accumulates products into an internal per-lane psum store.
- Handles read-modify-write hazards by forwarding, supports an overwrite-on-first-touch pass mode, and provides an end-of-pass drain/done protocol.
- Sits between the replica/kernel buffers and the psum-to-IFFT path, replacing the fixed delay-line read/write scheme.

Parameters:
DATALEN, 16, bits per real/imag component (two's complement)
FRACLEN, 14, fractional bits of kernel coefficient; product shifted right by this
PARAKRN, 8, parallel kernel lanes
INDXLEN, 6, spectral index width; psum depth = 2**INDXLEN per lane

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a pass (accepted only in IDLE)
cfg_first  in  1  sampled with start; 1 = first entry touch in pass overwrites, 0 = accumulate
s_valid  in  1  input beat valid
s_ready  out  1  input beat ready
s_last  in  1  last beat of pass
s_indx  in  INDXLEN  psum address for beat
s_act  in  2*DATALEN  input coefficient {imag,real}
s_krn  in  PARAKRN*2*DATALEN  kernel coefficients, lane k at [k*2*DATALEN +: 2*DATALEN]
s_kmask  in  PARAKRN  lane enable (sparse kernel nonzero)
rd_en  in  1  psum read strobe
rd_addr  in  INDXLEN  psum read address
rd_data  out  PARAKRN*2*DATALEN  psum read data, 1-cycle latency
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: state=IDLE, s_ready=0, done=0, busy=0, rd_data=0, pipeline valids=0, touched bitmap=0; psum contents undefined.
- FSM: IDLE -start-> ACCUM; ACCUM -(s_valid&s_ready&s_last)-> DRAIN; DRAIN -(pipeline empty)-> DONE; DONE -> IDLE (done=1 for this cycle only).
- start while not IDLE is ignored. On accepted start: latch cfg_first, clear touched bitmap.
- s_ready=1 only in ACCUM; no backpressure inside pipeline.
- Pipeline, 3 stages after accept:
  - S1: registered complex multiply per lane: re=(ar*br-ai*bi)>>>FRACLEN, im=(ar*bi+ai*br)>>>FRACLEN, arithmetic shift, truncated to DATALEN.
  - S2: psum read at index.
  - S3: add and write, masked per lane by s_kmask.
- Hazard: if S2 index equals S3 write index, S2 uses the S3 result (per lane, only where S3 lane mask set) instead of the store. Back-to-back identical indices accumulate correctly.
- Overwrite mode: if latched cfg_first=1 and touched[index]=0, write the product (not sum) for enabled lanes. touched[index] is set on any S3 write of that index, including all-lanes-masked beats. Forwarding respects this rule.
- Masked lanes leave psum unchanged.
- DRAIN lasts exactly 3 cycles after the last accept; done is asserted 4 cycles after the s_last handshake.
- Read port: valid only in IDLE; rd_data registered 1 cycle after rd_en. In other states rd_data holds its value. Simultaneous start and rd_en in IDLE: read still served.
- Default arithmetic (feature off): adds and product narrowing wrap modulo 2**DATALEN.
- Reset mid-pass: return to IDLE immediately, in-flight beats dropped, no done pulse.

Optional Feature:
CMAC_SAT_EN
- Defined: product narrowing and accumulation saturate to [-2**(DATALEN-1), 2**(DATALEN-1)-1] per component.
- Undefined: both wrap.

Decomposition:
- Package cmac_pkg: cmplx_t struct {re,im} of DATALEN, state enum, MAC_LAT=3 constant, sat/wrap narrowing function.
- One sub-module: cmplx_mul_pipe, the single-lane registered complex multiplier, instantiated PARAKRN times.

Test Plan:
- Overwrite pass: start, cfg_first=1; beat idx=5, act=(16384,0), krn lane0=(100,-50), mask=1 -> done 4 cycles after last; read idx5 lane0 = (100,-50).
- Accumulate hazard: cfg_first=0 after test 1; three consecutive beats idx=5, same operands -> lane0 = (400,-200) (forwarding exercised).
- Sparse mask: mask=8'b0000_0010, idx=7 -> only lane1 changes; lane0 at idx7 unchanged from preload.
- Saturation: preload 32000; add product 2000 -> with CMAC_SAT_EN reads 32767; without it reads -31536.
- Protocol: start during ACCUM ignored; s_ready low in DRAIN/DONE/IDLE; rd_en during ACCUM leaves rd_data unchanged.
- Reset mid-pass: assert rst 1 cycle after 2 accepts -> busy=0, s_ready=0, no done pulse; new pass works normally.
